ud_direction_decoder: RTL and testbench



---
 rtl/ud_direction_decoder_pkg.sv | 14 +
 rtl/ud_step_classify.sv | 28 ++
 rtl/ud_direction_decoder.sv | 152 +++++++++++++++
 tb/tb_ud_direction_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ud_direction_decoder_pkg.sv
// Shared types and glyph constants for the up/down counter display and its direction decoder.
package ud_direction_decoder_pkg;

  typedef enum logic [1:0] {StIdle, StTrack, StLocked, StErr} state_e;

  typedef enum logic [1:0] {StepUp, StepDown, StepHold, StepBad} step_e;

  // Segments a..g map to bits 0..6, active-high.
  localparam logic [6:0] SEG_U    = 7'b0111110;
  localparam logic [6:0] SEG_D    = 7'b1011110;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_E    = 7'b1111001;

endpackage

// File: rtl/ud_step_classify.sv
// Classifies the modular difference between two successive count samples.
module ud_step_classify
  import ud_direction_decoder_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] prev,
  input  logic [W-1:0] count_in,
  output step_e        step
);

  logic [W-1:0] delta;

  // Modular subtraction makes 15->0 an UP step and 0->15 a DOWN step.
  assign delta = count_in - prev;

  always_comb begin
    step = StepBad;
    if (delta == W'(1)) begin
      step = StepUp;
    end else if (delta == {W{1'b1}}) begin
      step = StepDown;
    end else if (delta == '0) begin
      step = StepHold;
    end
  end

endmodule

// File: rtl/ud_direction_decoder.sv
// Recovers counting direction from a sampled up/down count stream and flags illegal jumps.
module ud_direction_decoder
  import ud_direction_decoder_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned C      = 8
) (
  input  logic         cp,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] count_in,
  output logic         dir,
  output logic         locked,
  output logic         err,
  output logic [C-1:0] step_cnt,
  output logic [6:0]   display
);

  localparam logic [3:0]   LockN    = 4'(LOCK_N);
  localparam logic [C-1:0] StepMax  = '1;
  // A lock threshold wider than the counter starts it saturated.
  localparam logic [C-1:0] LockInit = (LOCK_N >= (1 << C)) ? StepMax : C'(LOCK_N);

  state_e       state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic         cand_q, cand_d;
  logic [3:0]   run_len_q, run_len_d;
  logic         dir_q, dir_d;
  logic         locked_q, locked_d;
  logic         err_q, err_d;
  logic [C-1:0] step_cnt_q, step_cnt_d;
  logic [6:0]   display_q, display_d;

  step_e        step;
  logic         step_up;
  logic         cand_n;
  logic [3:0]   run_n;

  ud_step_classify #(
    .W(W)
  ) u_classify (
    .prev     (prev_q),
    .count_in (count_in),
    .step     (step)
  );

  assign step_up = (step == StepUp);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cand_d     = cand_q;
    run_len_d  = run_len_q;
    dir_d      = dir_q;
    locked_d   = locked_q;
    err_d      = err_q;
    step_cnt_d = step_cnt_q;
    display_d  = display_q;
    cand_n     = cand_q;
    run_n      = run_len_q;

    if (in_valid) begin
      prev_d = count_in;
      unique case (state_q)
        StIdle, StErr: begin
          state_d   = StTrack;
          run_len_d = '0;
          err_d     = 1'b0;
          display_d = SEG_DASH;
        end
        StTrack: begin
          if (step == StepUp || step == StepDown) begin
            if (step_up == cand_q && run_len_q != '0) begin
              run_n = run_len_q + 4'd1;
            end else begin
              cand_n = step_up;
              run_n  = 4'd1;
            end
            cand_d    = cand_n;
            run_len_d = run_n;
            if (run_n >= LockN) begin
              state_d    = StLocked;
              dir_d      = cand_n;
              locked_d   = 1'b1;
              step_cnt_d = LockInit;
              display_d  = cand_n ? SEG_U : SEG_D;
            end
          end else if (step == StepBad) begin
            state_d    = StErr;
            err_d      = 1'b1;
            locked_d   = 1'b0;
            step_cnt_d = '0;
            display_d  = SEG_E;
          end
        end
        StLocked: begin
          if (step == StepUp || step == StepDown) begin
            if (step_up == dir_q) begin
              if (step_cnt_q != StepMax) step_cnt_d = step_cnt_q + C'(1);
            end else begin
              state_d    = StTrack;
              locked_d   = 1'b0;
              step_cnt_d = '0;
              cand_d     = step_up;
              run_len_d  = 4'd1;
              display_d  = SEG_DASH;
            end
          end else if (step == StepBad) begin
            state_d    = StErr;
            err_d      = 1'b1;
            locked_d   = 1'b0;
            step_cnt_d = '0;
            display_d  = SEG_E;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      cand_q     <= 1'b0;
      run_len_q  <= '0;
      dir_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      step_cnt_q <= '0;
      display_q  <= SEG_DASH;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cand_q     <= cand_d;
      run_len_q  <= run_len_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      step_cnt_q <= step_cnt_d;
      display_q  <= display_d;
    end
  end

  assign dir      = dir_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign step_cnt = step_cnt_q;
  assign display  = display_q;

endmodule

// File: tb/tb_ud_direction_decoder.sv
// Directed-vector bench for ud_direction_decoder; a second instance with C=2 covers saturation.
module tb_ud_direction_decoder;

  localparam logic [6:0] GlyphU    = 7'b0111110;
  localparam logic [6:0] GlyphD    = 7'b1011110;
  localparam logic [6:0] GlyphDash = 7'b1000000;
  localparam logic [6:0] GlyphE    = 7'b1111001;

  logic       cp;
  logic       reset;
  logic       in_valid;
  logic [3:0] count_in;

  logic       dir, locked, err;
  logic [7:0] step_cnt;
  logic [6:0] display;

  logic       dir2, locked2, err2;
  logic [1:0] step_cnt2;
  logic [6:0] display2;

  int n_checks;
  int n_fail;

  ud_direction_decoder #(.W(4), .LOCK_N(3), .C(8)) u_dut (
    .cp       (cp),
    .reset    (reset),
    .in_valid (in_valid),
    .count_in (count_in),
    .dir      (dir),
    .locked   (locked),
    .err      (err),
    .step_cnt (step_cnt),
    .display  (display)
  );

  ud_direction_decoder #(.W(4), .LOCK_N(3), .C(2)) u_dut_c2 (
    .cp       (cp),
    .reset    (reset),
    .in_valid (in_valid),
    .count_in (count_in),
    .dir      (dir2),
    .locked   (locked2),
    .err      (err2),
    .step_cnt (step_cnt2),
    .display  (display2)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at that point too.
  task automatic push(input logic [3:0] v);
    in_valid = 1'b1;
    count_in = v;
    @(posedge cp);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    count_in = '0;
    repeat (2) @(posedge cp);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic d, input logic l, input logic e,
                           input logic [7:0] sc, input logic [6:0] disp);
    check({tag, ".dir"}, 32'(dir), 32'(d));
    check({tag, ".locked"}, 32'(locked), 32'(l));
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".step_cnt"}, 32'(step_cnt), 32'(sc));
    check({tag, ".display"}, 32'(display), 32'(disp));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    count_in = '0;
    #2;
    do_reset();
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, GlyphDash);

    // 1: plain up stream locks after the 4th sample.
    push(4'd3);
    push(4'd4);
    push(4'd5);
    check("t1_pre_lock", 32'(locked), 32'd0);
    push(4'd6);
    check_all("t1_lock", 1'b1, 1'b1, 1'b0, 8'd3, GlyphU);

    // 2: wrap 15->0 counts as up; reversal drops lock.
    do_reset();
    push(4'd14);
    push(4'd15);
    push(4'd0);
    push(4'd1);
    check_all("t2_lock", 1'b1, 1'b1, 1'b0, 8'd3, GlyphU);
    push(4'd2);
    check("t2_cnt4", 32'(step_cnt), 32'd4);
    push(4'd1);
    check("t2_rev.locked", 32'(locked), 32'd0);
    check("t2_rev.step_cnt", 32'(step_cnt), 32'd0);
    check("t2_rev.display", 32'(display), 32'(GlyphDash));

    // 3: down stream through 0->15, then a HOLD sample.
    do_reset();
    push(4'd2);
    push(4'd1);
    push(4'd0);
    push(4'd15);
    check_all("t3_lock", 1'b0, 1'b1, 1'b0, 8'd3, GlyphD);
    push(4'd15);
    check_all("t3_hold", 1'b0, 1'b1, 1'b0, 8'd3, GlyphD);

    // 4: illegal jump, then re-acquire.
    do_reset();
    push(4'd2);
    push(4'd3);
    push(4'd4);
    push(4'd5);
    check("t4_locked", 32'(locked), 32'd1);
    push(4'd9);
    check_all("t4_err", 1'b1, 1'b0, 1'b1, 8'd0, GlyphE);
    push(4'd9);
    check("t4_reacq.err", 32'(err), 32'd0);
    check("t4_reacq.display", 32'(display), 32'(GlyphDash));
    push(4'd10);
    push(4'd11);
    check("t4_pre_relock", 32'(locked), 32'd0);
    push(4'd12);
    check_all("t4_relock", 1'b1, 1'b1, 1'b0, 8'd3, GlyphU);

    // 5: idle cycles change nothing, even with a bad value on count_in.
    count_in = 4'd0;
    repeat (10) @(posedge cp);
    #1;
    check_all("t5_idle", 1'b1, 1'b1, 1'b0, 8'd3, GlyphU);
    push(4'd13);
    check("t5_prev_kept", 32'(locked), 32'd1);
    check("t5_cnt", 32'(step_cnt), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check_all("t5_async_reset", 1'b0, 1'b0, 1'b0, 8'd0, GlyphDash);
    #1;
    reset = 1'b1;
    @(posedge cp);
    #1;

    // 6: ten up steps; the C=2 instance saturates at 3.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      push(4'(i));
      if (i == 3) begin
        check("t6_lock_c2", 32'(step_cnt2), 32'd3);
        check("t6_lock_c8", 32'(step_cnt), 32'd3);
      end
    end
    check("t6_sat.step_cnt", 32'(step_cnt2), 32'd3);
    check("t6_sat.dir", 32'(dir2), 32'd1);
    check("t6_sat.locked", 32'(locked2), 32'd1);
    check("t6_sat.display", 32'(display2), 32'(GlyphU));
    check("t6_wide.step_cnt", 32'(step_cnt), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
